// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single mainMem port between the fetch (I) and memory-stage (D) requesters.
// Every access runs IDLE -> ISSUE -> RESP. A misaligned D request goes IDLE -> ERR and never touches memory.
module mem_port_arbiter #(
   parameter int unsigned MAX_D_STREAK = 4,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [0:ADDR_W-1] i_addr,
   output logic              i_ack,
   output logic [0:ADDR_W-1] i_rdata,
   output logic              i_stall,
   input  logic              d_req,
   input  logic              d_wren,
   input  logic [0:ADDR_W-1] d_addr,
   input  logic [0:ADDR_W-1] d_wdata,
   output logic              d_ack,
   output logic [0:ADDR_W-1] d_rdata,
   output logic              d_err,
   output logic [0:ADDR_W-1] mem_addr,
   output logic [0:ADDR_W-1] mem_data_in,
   output logic [1:0]        mem_acc_size,
   output logic              mem_wren,
   output logic              mem_enable,
   input  logic              mem_busy,
   input  logic [0:ADDR_W-1] mem_data_out
);

   localparam int unsigned SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;
   localparam logic [1:0] S_ERR   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic              owner_d_q, owner_d_d;
   logic              wren_q, wren_d;
   logic [0:ADDR_W-1] addr_q, addr_d;
   logic [0:ADDR_W-1] wdata_q, wdata_d;
   logic [0:ADDR_W-1] i_rdata_q, i_rdata_d;
   logic [0:ADDR_W-1] d_rdata_q, d_rdata_d;
   logic              streak_full, d_misaligned, grant_i, grant_d;

   always_comb begin
      state_d      = state_q;
      streak_d     = streak_q;
      owner_d_d    = owner_d_q;
      wren_d       = wren_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      streak_full  = (streak_q == STREAK_MAX);
      d_misaligned = (d_addr[ADDR_W-2:ADDR_W-1] != 2'b00);
      // D normally wins; a waiting fetch is forced through once D has used up its streak
      grant_i      = i_req && (!d_req || streak_full);
      grant_d      = d_req && !grant_i;

      case (state_q)
         S_IDLE: begin
            if (grant_i) begin
               owner_d_d = 1'b0;
               wren_d    = 1'b0;
               addr_d    = i_addr;
               streak_d  = '0;
               state_d   = S_ISSUE;
            end else if (grant_d) begin
               if (i_req && !streak_full) begin
                  streak_d = streak_q + SW'(1);
               end
               if (d_misaligned) begin
                  state_d = S_ERR;
               end else begin
                  owner_d_d = 1'b1;
                  wren_d    = d_wren;
                  addr_d    = d_addr;
                  wdata_d   = d_wdata;
                  state_d   = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (!mem_busy) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (!wren_q) begin
               if (owner_d_q) begin
                  d_rdata_d = mem_data_out;
               end else begin
                  i_rdata_d = mem_data_out;
               end
            end
            state_d = S_IDLE;
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         streak_q  <= '0;
         owner_d_q <= 1'b0;
         wren_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         owner_d_q <= owner_d_d;
         wren_q    <= wren_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // Read data arrives in the RESP cycle, so it is forwarded alongside the ack and held afterwards
   assign i_ack        = (state_q == S_RESP) && !owner_d_q;
   assign d_ack        = (state_q == S_RESP) && owner_d_q;
   assign d_err        = (state_q == S_ERR);
   assign i_rdata      = i_ack ? mem_data_out : i_rdata_q;
   assign d_rdata      = (d_ack && !wren_q) ? mem_data_out : d_rdata_q;
   assign i_stall      = i_req & ~i_ack;
   assign mem_enable   = (state_q == S_ISSUE);
   assign mem_wren     = (state_q == S_ISSUE) && wren_q;
   assign mem_addr     = addr_q;
   assign mem_data_in  = wdata_q;
   assign mem_acc_size = 2'b00;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single mainMem port between the fetch stage (I-port, read-only) and the memory stage (D-port, load/store).
- Sequences every access as ISSUE then RESPONSE, and handles mainMem busy back-pressure.
- Returns read data with a one-cycle ack pulse.
- Drives the fetch stall so fetch holds pc_out while its request is pending.

Parameters:
- MAX_D_STREAK, 4: consecutive D-port grants allowed while I-port is waiting; the next grant then goes to the I-port.
- ADDR_W, 32: address and data width; bit 0 is the MSB, so [ADDR_W-2:ADDR_W-1] are the byte-offset bits.

Ports:
- clock  in  1  system clock, all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request; held until i_ack
- i_addr  in  32  fetch address
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle
- i_rdata  out  32  instruction word
- i_stall  out  1  i_req & ~i_ack; feeds fetch stall
- d_req  in  1  data request; held until d_ack or d_err
- d_wren  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle completion pulse; d_rdata valid for loads
- d_rdata  out  32  load data
- d_err  out  1  one-cycle pulse: misaligned address, no memory access made
- mem_addr  out  32  to mainMem addr
- mem_data_in  out  32  to mainMem data_in
- mem_acc_size  out  2  always 2'b00 (single word)
- mem_wren  out  1  to mainMem wren
- mem_enable  out  1  to mainMem enable
- mem_busy  in  1  from mainMem busy
- mem_data_out  in  32  from mainMem data_out; valid the cycle after a read issue

Behaviour:
- Reset values:
  - i_ack, d_ack, d_err, mem_wren, mem_enable = 0.
  - mem_addr, mem_data_in, i_rdata, d_rdata = 0; mem_acc_size = 2'b00.
  - State IDLE, streak counter 0.
- States:
  - IDLE: arbitrate.
  - ISSUE: mem_enable = 1; mem_addr, mem_wren, mem_data_in driven from the latched request.
  - RESP: mem_enable = 0.
- Arbitration (IDLE):
  - D-port has priority over I-port.
  - Exception: if i_req && streak == MAX_D_STREAK, grant I.
  - Streak increments on each D grant made while i_req = 1, saturating at MAX_D_STREAK; it clears on any I grant.
  - Grant latches owner, addr, wren and wdata; next state is ISSUE.
- Misaligned D address:
  - If d_addr[30:31] != 0 when D would win, go IDLE -> ERR. No ISSUE, no memory activity.
  - d_err pulses for one cycle, then return to IDLE.
  - The streak still counts this as a D grant.
- ISSUE:
  - If mem_busy = 1, stay in ISSUE with the same outputs (retry every cycle).
  - Otherwise go to RESP.
- RESP:
  - Capture mem_data_out into i_rdata or d_rdata for reads; rdata is unchanged for stores.
  - Pulse i_ack or d_ack in this cycle, then return to IDLE.
  - rdata holds its value until the next ack for that port.
- Latency: unloaded access is grant edge -> ISSUE -> RESP (ack) -> IDLE, i.e. ack 2 cycles after the request is sampled in IDLE. Throughput is 1 access per 3 cycles.
- Requester rules:
  - A requester must hold req and its operands stable until ack or err.
  - Operand changes after the grant are ignored because operands are latched.
  - The cycle after its ack, a port may assert req again.
- Simultaneous requests: i_req and d_req together in IDLE -> D wins unless the streak rule applies. The loser stays pending, and i_stall stays 1 throughout.
- Stores: mem_wren = 1 only during ISSUE of a D store. i_ack never coincides with d_ack.
- Reset mid-operation: any state returns to IDLE. Any in-flight access is dropped with no ack, mem_enable deasserts in the same cycle, and the streak clears.

Test Plan:
- Single fetch:
  - Preload 0x80020000 = 0x27BDFFE8.
  - Stimulus: i_req, i_addr = 0x80020000.
  - Required: mem_enable one cycle; i_ack 2 cycles after the request; i_rdata = 0x27BDFFE8; i_stall 1 until the ack cycle.
- Store then load:
  - Stimulus: D store 0xDEADBEEF to 0x80020100, then a load from the same address.
  - Required: mem_wren = 1 only in the store ISSUE cycle; the load d_ack returns d_rdata = 0xDEADBEEF.
- Contention:
  - Stimulus: i_req and d_req held high continuously, MAX_D_STREAK = 4.
  - Required: grant order D,D,D,D,I,D,D,D,D,I; no cycle with both acks.
- Busy back-pressure:
  - Stimulus: mem_busy high for 3 cycles during ISSUE.
  - Required: mem_addr and mem_enable held stable; ack arrives 3 cycles later than the unloaded case.
- Misaligned D-port:
  - Stimulus: d_addr = 0x80020002.
  - Required: d_err pulses, mem_enable never asserts, d_ack = 0; a following aligned request completes normally.
- Reset mid-operation:
  - Stimulus: reset asserted during ISSUE of an I fetch.
  - Required: next cycle mem_enable = 0 and no i_ack; after release, the re-issued fetch returns correct data.
